// File: rtl/fibonacci_pkg.sv
// Shared encodings for the Fibonacci term streamer.
// FSM states, overflow-policy modes and the mode decoder.
package fibonacci_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MODE_RESTART = 2'b00,
        MODE_HALT    = 2'b01,
        MODE_WRAP    = 2'b10
    } mode_e;

    // The unused code 11 behaves like WRAP.
    function automatic mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'b00:   decode_mode = MODE_RESTART;
            2'b01:   decode_mode = MODE_HALT;
            default: decode_mode = MODE_WRAP;
        endcase
    endfunction

endpackage

// File: rtl/fibonacci_stream_if.sv
// Valid/ready stream carrying one term and its index.
// The master produces terms; the slave consumes them.
interface fibonacci_stream_if #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 8
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_value;
    logic [IDX_W-1:0] out_index;

    modport master (
        output out_valid,
        output out_value,
        output out_index,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_value,
        input  out_index,
        output out_ready
    );
endinterface

// File: rtl/fib_step.sv
// One Fibonacci step: WIDTH+1-bit add of two terms.
// The top bit of the add is exported as carry.
module fib_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);
    assign {carry, sum} = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/fibonacci_stream.sv
// Streams a Fibonacci-like sequence from two seeds.
// Overflow policy is RESTART, HALT or WRAP.
module fibonacci_stream
    import fibonacci_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IDX_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   seed0,
    input  logic [WIDTH-1:0]   seed1,
    fibonacci_stream_if.master strm,
    output logic               busy,
    output logic               done,
    output logic               overflow
);

    state_e           state, state_n;
    mode_e            mode_q, mode_n;
    logic [WIDTH-1:0] prev, prev_n;
    logic [WIDTH-1:0] curr, curr_n;
    logic [WIDTH-1:0] s0_q, s0_n;
    logic [WIDTH-1:0] s1_q, s1_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic             last, last_n;
    logic             ovf_n;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             hs;

    fib_step #(.WIDTH(WIDTH)) u_step (
        .a     (prev),
        .b     (curr),
        .sum   (sum),
        .carry (carry)
    );

    assign hs = (state == S_RUN) && strm.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            mode_q   <= MODE_RESTART;
            prev     <= '0;
            curr     <= '0;
            s0_q     <= '0;
            s1_q     <= '0;
            idx      <= '0;
            last     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            mode_q   <= mode_n;
            prev     <= prev_n;
            curr     <= curr_n;
            s0_q     <= s0_n;
            s1_q     <= s1_n;
            idx      <= idx_n;
            last     <= last_n;
            overflow <= ovf_n;
        end
    end

    always_comb begin
        state_n = state;
        mode_n  = mode_q;
        prev_n  = prev;
        curr_n  = curr;
        s0_n    = s0_q;
        s1_n    = s1_q;
        idx_n   = idx;
        last_n  = last;
        ovf_n   = 1'b0;
        unique case (1'b1)
            start: begin
                state_n = S_RUN;
                mode_n  = decode_mode(mode);
                s0_n    = seed0;
                s1_n    = seed1;
                prev_n  = seed0;
                curr_n  = seed1;
                idx_n   = '0;
                last_n  = 1'b0;
            end
            // Carry still shifts so the last representable term is shown.
            (!start && hs && !last): begin
                prev_n = curr;
                curr_n = sum;
                idx_n  = idx + IDX_W'(1);
                ovf_n  = carry;
                if (carry && (mode_q != MODE_WRAP))
                    last_n = 1'b1;
            end
            (!start && hs && last): begin
                if (mode_q == MODE_HALT) begin
                    state_n = S_DONE;
                end else begin
                    prev_n = s0_q;
                    curr_n = s1_q;
                    idx_n  = '0;
                    last_n = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    assign strm.out_valid = (state == S_RUN);
    assign strm.out_value = prev;
    assign strm.out_index = idx;
    assign busy           = (state == S_RUN);
    assign done           = (state == S_DONE);

endmodule

// File: tb/tb_fibonacci_stream.sv
// Scoreboard bench for fibonacci_stream at WIDTH=8.
// Reference sequences are built with plain integer arithmetic.
module tb_fibonacci_stream;

    localparam int W  = 8;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [W-1:0]  seed0 = '0;
    logic [W-1:0]  seed1 = '0;
    logic          busy;
    logic          done;
    logic          overflow;

    fibonacci_stream_if #(.WIDTH(W), .IDX_W(IW)) sif ();

    fibonacci_stream #(.WIDTH(W), .IDX_W(IW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mode     (mode),
        .seed0    (seed0),
        .seed1    (seed1),
        .strm     (sif.master),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int val;
        int idx;
        bit ovf;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   ovf_seen = 0;
    bit   pend = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: t[k] = t[k-1] + t[k-2] over unbounded integers.
    // HALT/RESTART emit every term below 256; WRAP reduces mod 256.
    function automatic void gen(input int s0, input int s1,
                                input int m, input int n);
        exp_t e;
        int   t[$];
        int   a, b, nx, len;
        if (m == 0 || m == 1) begin
            t.push_back(s0);
            t.push_back(s1);
            while (t[t.size()-1] + t[t.size()-2] <= 255)
                t.push_back(t[t.size()-1] + t[t.size()-2]);
            len = t.size();
            if (m == 1) n = len;
            for (int i = 0; i < n; i++) begin
                e.val = t[i % len];
                e.idx = i % len;
                e.ovf = ((i % len) == len - 2);
                q.push_back(e);
            end
        end else begin
            a = s0;
            b = s1;
            for (int i = 0; i < n; i++) begin
                e.val = a;
                e.idx = i % 256;
                e.ovf = (a + b) > 255;
                q.push_back(e);
                nx = (a + b) % 256;
                a  = b;
                b  = nx;
            end
        end
    endfunction

    // Monitor: compares presented terms against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend = 1'b0;
            end else begin
                if (overflow) ovf_seen++;
                chk("overflow", int'(overflow), int'(pend));
                pend = 1'b0;
                if (sif.out_valid && sif.out_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_term: got value %0d index %0d, expected none",
                                 sif.out_value, sif.out_index);
                    end else begin
                        e = q.pop_front();
                        chk("value", int'(sif.out_value), e.val);
                        chk("index", int'(sif.out_index), e.idx);
                        pend = e.ovf && !start;
                    end
                end else if (sif.out_valid && !start && q.size() > 0) begin
                    chk("held_value", int'(sif.out_value), q[0].val);
                    chk("held_index", int'(sif.out_index), q[0].idx);
                end
            end
        end
    end

    task automatic do_start(input int m, input int s0, input int s1, input int n);
        start = 1'b1;
        mode  = 2'(m);
        seed0 = W'(s0);
        seed1 = W'(s1);
        gen(s0, s1, m, n);
    endtask

    task automatic run(input bit full, input int budget, output int cyc);
        cyc = 0;
        while (1) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (q.size() == 0) begin
                sif.out_ready = 1'b0;
                break;
            end
            if (cyc >= budget) begin
                checks++;
                errors++;
                $display("FAIL timeout: got %0d terms pending, expected 0", q.size());
                q.delete();
                sif.out_ready = 1'b0;
                break;
            end
            sif.out_ready = full ? 1'b1 : ($urandom_range(0, 2) != 0);
            cyc++;
        end
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int c, o0, s0, s1, m, n;
        sif.out_ready = 1'b0;
        #1;
        chk("rst_valid", int'(sif.out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_value", int'(sif.out_value), 0);
        chk("rst_index", int'(sif.out_index), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // HALT, 0/1, always ready: 14 terms, one per cycle.
        o0 = ovf_seen;
        do_start(1, 0, 1, 0);
        run(1'b1, 100, c);
        chk("halt_rate", c, 14);
        chk("halt_done", int'(done), 1);
        chk("halt_valid", int'(sif.out_valid), 0);
        chk("halt_busy", int'(busy), 0);
        sif.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("halt_ovf_pulses", ovf_seen - o0, 1);
        chk("done_holds", int'(done), 1);
        chk("done_no_valid", int'(sif.out_valid), 0);
        sif.out_ready = 1'b0;

        // WRAP, 0/1: passes 233 -> 121 -> 98.
        do_start(2, 0, 1, 20);
        run(1'b0, 1000, c);

        // RESTART, Lucas seeds: returns to 2 at index 0.
        do_start(0, 2, 1, 15);
        run(1'b0, 1000, c);

        // Start with a same-cycle handshake at index 5.
        do_start(2, 0, 1, 6);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            sif.out_ready = 1'b1;
            if (i == 5) do_start(2, 3, 4, 8);
        end
        run(1'b0, 1000, c);

        // Randomized seeds, modes and back-pressure.
        for (int r = 0; r < 8; r++) begin
            s0 = $urandom_range(0, 255);
            s1 = $urandom_range(0, 255);
            m  = $urandom_range(0, 3);
            n  = $urandom_range(8, 40);
            do_start(m, s0, s1, n);
            run(1'b0, 3000, c);
            if (m == 1) begin
                chk("rand_halt_done", int'(done), 1);
                chk("rand_halt_valid", int'(sif.out_valid), 0);
            end
        end

        // Reset in the middle of a run.
        do_start(2, 1, 1, 30);
        repeat (4) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            sif.out_ready = 1'b1;
        end
        reset = 1'b1;
        #1;
        chk("midrst_valid", int'(sif.out_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_value", int'(sif.out_value), 0);
        chk("midrst_index", int'(sif.out_index), 0);
        q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_busy", int'(busy), 0);
        chk("idle_valid", int'(sif.out_valid), 0);
        chk("idle_done", int'(done), 0);
        sif.out_ready = 1'b0;
        do_start(1, 5, 8, 0);
        run(1'b0, 1000, c);
        chk("post_rst_done", int'(done), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fibonacci_stream.md
FIBONACCI_STREAM -- requirements
Module: fibonacci_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 32, term width in bits (minimum 4).
REQ-002 SHALL have parameter IDX_W, default 8, term-index width in bits.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  single-cycle request to (re)load the seeds and begin a sequence.
REQ-006 SHALL have port mode  input  2  overflow policy, sampled only on an accepted start: 00 RESTART, 01 HALT, 10 WRAP, 11 treated as WRAP.
REQ-007 SHALL have port seed0  input  WIDTH  term 0, sampled on an accepted start.
REQ-008 SHALL have port seed1  input  WIDTH  term 1, sampled on an accepted start.
REQ-009 SHALL have port out_valid  output  1  out_value and out_index hold a valid term.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the term; a handshake occurs when out_valid and out_ready are both 1.
REQ-011 SHALL have port out_value  output  WIDTH  current term.
REQ-012 SHALL have port out_index  output  IDX_W  index of the current term, modulo 2^IDX_W.
REQ-013 SHALL have port busy  output  1  high in state RUN.
REQ-014 SHALL have port done  output  1  high in state DONE.
REQ-015 SHALL have port overflow  output  1  one-cycle pulse on every carry out of the term adder.

Function
REQ-016 SHALL implement states IDLE, RUN and DONE; out_valid SHALL equal (state==RUN).
REQ-017 SHALL accept start in any state, load prev=seed0, curr=seed1, index=0, last=0, latch mode, and enter RUN on the next edge.
REQ-018 SHALL present prev on out_value and index on out_index; both SHALL hold stable while out_valid=1 and out_ready=0.
REQ-019 SHALL, on a handshake with last=0, compute sum=prev+curr at WIDTH+1 bits, then set prev<=curr, curr<=sum[WIDTH-1:0] and index<=index+1 (wrapping).
REQ-020 SHALL, in WRAP mode, continue modulo 2^WIDTH indefinitely and pulse overflow when sum[WIDTH]=1.
REQ-021 SHALL, in RESTART or HALT mode, when sum[WIDTH]=1, still shift prev<=curr, set last=1 and pulse overflow, so that every representable term is emitted.
REQ-022 SHALL, on a handshake with last=1, reload the latched seeds with index=0 in RESTART mode, or enter DONE with out_valid=0 in HALT mode.
REQ-023 SHALL give start priority over a same-cycle handshake; the accepted term counts as consumed and nothing else advances.
REQ-024 SHALL remain in DONE until start, which also exits IDLE; without start, out_ready SHALL have no effect in IDLE or DONE.
REQ-025 SHALL produce the first term one cycle after start, then sustain one term per cycle while out_ready=1.

Reset
REQ-026 SHALL, while reset=1, immediately force state=IDLE, prev=curr=0, index=0, last=0, latched mode=RESTART, latched seeds=0, and all outputs to 0.
REQ-027 SHALL abandon any sequence in progress when reset asserts mid-operation; after release it SHALL wait in IDLE for start.

Structure
REQ-028 SHALL take the state encoding and mode encodings (MODE_RESTART, MODE_HALT, MODE_WRAP) from a shared package fibonacci_pkg.
REQ-029 SHALL place the WIDTH+1-bit adder and carry extraction in a sub-module fib_step (inputs a, b; outputs sum, carry).

Verification
REQ-030 SHALL verify: WIDTH=8, HALT, seeds 0/1, out_ready=1 -> values 0,1,1,2,3,5,8,13,21,34,55,89,144,233 at indices 0..13, one overflow pulse, then done=1 and out_valid=0.
REQ-031 SHALL verify: WIDTH=8, WRAP, seeds 0/1 -> the term after 233 is 121, then 98; overflow pulses when 377 is formed.
REQ-032 SHALL verify: WIDTH=8, RESTART, seeds 2/1 -> Lucas values 2,1,3,4,7,...; after the last term below 256 is accepted, out_value returns to 2 with out_index=0.
REQ-033 SHALL verify: out_ready toggled pseudo-randomly -> out_value and out_index stay stable while stalled, and no term is skipped or duplicated.
REQ-034 SHALL verify: start at index 5 with a same-cycle handshake, new seeds 3/4 -> the next term is 3 at index 0.
REQ-035 SHALL verify: reset asserted mid-RUN -> out_valid, busy and out_value are 0 in the same cycle, and the block stays in IDLE after release until start.
